// File: rtl/interp_mac_pipe_if.sv
// Beat-level handshake bundle for the interpolation weighted-sum pipeline.
// The slave view is the pipeline itself; the master view is its source/sink.
interface interp_mac_pipe_if #(
    parameter int TAPS   = 4,
    parameter int DATA_W = 8,
    parameter int COEF_W = 10,
    parameter int OUT_W  = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic [TAPS*DATA_W-1:0]   pix_in;
    logic [TAPS*COEF_W-1:0]   coef_in;
    logic                     round_mode;
    logic                     out_valid;
    logic                     out_ready;
    logic [OUT_W-1:0]         result;
    logic                     sat;

    modport slave (
        input  in_valid, pix_in, coef_in, round_mode, out_ready,
        output in_ready, out_valid, result, sat
    );

    modport master (
        output in_valid, pix_in, coef_in, round_mode, out_ready,
        input  in_ready, out_valid, result, sat
    );
endinterface

// File: rtl/interp_mac_pipe.sv
// Fixed-point weighted sum of TAPS pixels: multiply stage, registered adder tree,
// then round/shift/clamp to an unsigned pixel. One global stall enable for every stage.
module interp_mac_pipe #(
    parameter int TAPS   = 4,
    parameter int DATA_W = 8,
    parameter int COEF_W = 10,
    parameter int FRAC_W = 8,
    parameter int OUT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    interp_mac_pipe_if.slave bus
);
    localparam int L   = $clog2(TAPS);
    localparam int P_W = DATA_W + COEF_W + 1;
    localparam int S_W = P_W + L;
    localparam int T_W = S_W + 1;

    localparam logic signed [T_W-1:0] HALF  = {{(T_W-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
    localparam logic signed [T_W-1:0] ZERO  = '0;
    localparam logic signed [T_W-1:0] MAX_Q = {{(T_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

    logic                    ce;
    logic signed [P_W-1:0]   prod_d [TAPS];
    // Level 0 holds the products, level k holds the k-th adder-tree row.
    logic signed [S_W-1:0]   tree_d [L+1][TAPS];
    logic signed [S_W-1:0]   tree_q [L+1][TAPS];
    logic [L:0]              v_d, v_q;
    logic [L:0]              rnd_d, rnd_q;
    logic signed [T_W-1:0]   t_r, q_r;
    logic                    out_valid_d, out_valid_q;
    logic [OUT_W-1:0]        result_d, result_q;
    logic                    sat_d, sat_q;

    // Reset forces the enable so a stalled output cannot block the flush.
    assign ce            = rst || !out_valid_q || bus.out_ready;
    assign bus.in_ready  = ce;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.sat       = sat_q;

    always_comb begin
        for (int k = 0; k <= L; k++) begin
            for (int j = 0; j < TAPS; j++) begin
                tree_d[k][j] = '0;
            end
        end
        v_d   = {v_q[L-1:0], bus.in_valid};
        rnd_d = {rnd_q[L-1:0], bus.round_mode};
        for (int i = 0; i < TAPS; i++) begin
            prod_d[i]    = $signed({1'b0, bus.pix_in[i*DATA_W +: DATA_W]})
                         * $signed(bus.coef_in[i*COEF_W +: COEF_W]);
            tree_d[0][i] = {{L{prod_d[i][P_W-1]}}, prod_d[i]};
        end
        // Tree rows carry full width, so no level can overflow.
        for (int k = 1; k <= L; k++) begin
            for (int j = 0; j < (TAPS >> k); j++) begin
                tree_d[k][j] = tree_q[k-1][2*j] + tree_q[k-1][2*j+1];
            end
        end
    end

    always_comb begin
        t_r         = $signed({tree_q[L][0][S_W-1], tree_q[L][0]}) + (rnd_q[L] ? HALF : ZERO);
        q_r         = t_r >>> FRAC_W;
        out_valid_d = v_q[L];
        result_d    = q_r[OUT_W-1:0];
        sat_d       = 1'b0;
        if (q_r[T_W-1]) begin
            result_d = '0;
            sat_d    = v_q[L];
        end else if (q_r > MAX_Q) begin
            result_d = '1;
            sat_d    = v_q[L];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q         <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            sat_q       <= 1'b0;
        end else if (ce) begin
            v_q         <= v_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            sat_q       <= sat_d;
        end
    end

    // NOTE: datapath registers carry no reset; their contents only matter behind a set valid bit.
    always_ff @(posedge clk) begin
        if (ce) begin
            tree_q <= tree_d;
            rnd_q  <= rnd_d;
        end
    end
endmodule

// File: tb/tb_interp_mac_pipe.sv
// Directed bench for interp_mac_pipe: vector table for arithmetic/clamp cases,
// plus hand-written backpressure and mid-stream reset sequences.
module tb_interp_mac_pipe;
    localparam int TAPS = 4, DATA_W = 8, COEF_W = 10, FRAC_W = 8, OUT_W = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    interp_mac_pipe_if #(.TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W)) bus ();

    interp_mac_pipe #(
        .TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .FRAC_W(FRAC_W), .OUT_W(OUT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    p [4];
        int    c [4];
        bit    rnd;
        int    exp_res;
        bit    exp_sat;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input string name, input int p0, input int p1, input int p2, input int p3,
                           input int c0, input int c1, input int c2, input int c3,
                           input bit rnd, input int exp_res, input bit exp_sat);
        vec_t v;
        v.name = name;
        v.p[0] = p0; v.p[1] = p1; v.p[2] = p2; v.p[3] = p3;
        v.c[0] = c0; v.c[1] = c1; v.c[2] = c2; v.c[3] = c3;
        v.rnd = rnd; v.exp_res = exp_res; v.exp_sat = exp_sat;
        vecs.push_back(v);
    endtask

    task automatic set_beat(input int p [4], input int c [4], input bit rnd);
        logic [31:0] pw, cw;
        for (int i = 0; i < TAPS; i++) begin
            pw = p[i];
            cw = c[i];
            bus.pix_in[i*DATA_W +: DATA_W]  = pw[DATA_W-1:0];
            bus.coef_in[i*COEF_W +: COEF_W] = cw[COEF_W-1:0];
        end
        bus.round_mode = rnd;
    endtask

    task automatic set_unit(input int k);
        int p [4];
        int c [4];
        p = '{k, 0, 0, 0};
        c = '{256, 0, 0, 0};
        set_beat(p, c, 1'b0);
    endtask

    initial begin
        int  cycles;
        int  sent, rcv, extra;
        bit  stall_prev, acc, hs;
        logic [OUT_W-1:0] prev_res;

        add_vec("exact_sum",    10, 20, 30, 40,   64,  64, 64, 64, 1'b0,  25, 1'b0);
        add_vec("round_up",      1,  0,  0,  0,  128,   0,  0,  0, 1'b1,   1, 1'b0);
        add_vec("trunc",         1,  0,  0,  0,  128,   0,  0,  0, 1'b0,   0, 1'b0);
        add_vec("neg_round",     3,  0,  0,  0, -128,   0,  0,  0, 1'b1,   0, 1'b1);
        add_vec("high_clamp",  255,255,255,255,  128, 128,128,128, 1'b0, 255, 1'b1);
        add_vec("high_exact",  255,255,255,255,   64,  64, 64, 64, 1'b0, 255, 1'b0);
        add_vec("low_clamp",   200, 10,  0,  0,  -64, 320,  0,  0, 1'b0,   0, 1'b1);
        add_vec("after_low",    16,  0,  0,  0,  256,   0,  0,  0, 1'b0,  16, 1'b0);
        add_vec("coef_min",    255,255,255,255, -512,-512,-512,-512, 1'b1, 0, 1'b1);
        add_vec("small_neg_r", 100, 50,  0,  0, -256, 511,  0,  0, 1'b1,   0, 1'b0);
        add_vec("small_neg_t", 100, 50,  0,  0, -256, 511,  0,  0, 1'b0,   0, 1'b1);
        add_vec("half_r",        3,  0,  0,  0,  128,   0,  0,  0, 1'b1,   2, 1'b0);
        add_vec("half_t",        3,  0,  0,  0,  128,   0,  0,  0, 1'b0,   1, 1'b0);

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.pix_in = '0;
        bus.coef_in = '0;
        bus.round_mode = 1'b0;
        step();
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_result", bus.result, 0);
        check("rst_sat", bus.sat, 0);
        step();
        rst = 1'b0;

        foreach (vecs[n]) begin
            set_beat(vecs[n].p, vecs[n].c, vecs[n].rnd);
            bus.in_valid = 1'b1;
            #1;
            check({vecs[n].name, "_in_ready"}, bus.in_ready, 1);
            step();
            bus.in_valid = 1'b0;
            cycles = 1;
            while (!bus.out_valid && cycles < 20) begin
                step();
                cycles++;
            end
            check({vecs[n].name, "_latency"}, cycles, 4);
            check({vecs[n].name, "_result"}, bus.result, vecs[n].exp_res);
            check({vecs[n].name, "_sat"}, bus.sat, vecs[n].exp_sat);
            step();
        end

        // Backpressure stream with random out_ready.
        sent = 0; rcv = 0; stall_prev = 1'b0; prev_res = '0;
        set_unit(0);
        bus.in_valid = 1'b1;
        for (int cyc = 0; cyc < 400 && rcv < 20; cyc++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            #1;
            check("bp_in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
            if (stall_prev) check("bp_stall_hold", {bus.out_valid, bus.result}, {1'b1, prev_res});
            acc = bus.in_valid && bus.in_ready;
            hs  = bus.out_valid && bus.out_ready;
            if (hs) begin
                check("bp_order", bus.result, rcv);
                rcv++;
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            prev_res   = bus.result;
            step();
            if (acc) begin
                sent++;
                if (sent < 20) set_unit(sent);
                else bus.in_valid = 1'b0;
            end
        end
        check("bp_count", rcv, 20);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.out_valid) extra++;
        end
        check("bp_no_dup", extra, 0);

        // Mid-stream reset flushes in-flight beats and beats offered during reset.
        for (int k = 100; k < 103; k++) begin
            set_unit(k);
            bus.in_valid = 1'b1;
            step();
        end
        set_unit(55);
        rst = 1'b1;
        #1;
        check("rst_mid_in_ready", bus.in_ready, 1);
        step();
        rst = 1'b0;
        check("rst_mid_flush", bus.out_valid, 0);
        set_unit(7);
        step();
        bus.in_valid = 1'b0;
        cycles = 1;
        while (!bus.out_valid && cycles < 20) begin
            step();
            cycles++;
        end
        check("rst_mid_latency", cycles, 4);
        check("rst_mid_result", bus.result, 7);
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.out_valid) extra++;
        end
        check("rst_mid_no_old", extra, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
